fetch_issue_unit: RTL and testbench

Instruction fetch and issue stage that produces the opcode and instruction word consumed by the decode-stage control unit. It holds the PC, runs a request/valid handshake to instruction memory, and buffers one returned instruction while decode is stalled. It also owns the IF/ID pipeline register and applies branch redirects from execute.

---
 rtl/fetch_issue_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_issue_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_unit.sv
// Instruction fetch/issue stage: PC, single-outstanding imem handshake, one-entry skid buffer, IF/ID register.
// Optional `PERF_COUNTERS_EN adds saturating fetchCount / discardCount outputs.
module fetch_issue_unit #(
  parameter int          WIDTH       = 32,
  parameter int          OPCODEWIDTH = 4,
  parameter int          ADDRWIDTH   = 16,
  parameter int unsigned RESETPC     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imemReqF,
  output logic [ADDRWIDTH-1:0]   imemAddrF,
  input  logic [WIDTH-1:0]       imemDataF,
  input  logic                   imemValidF,
  input  logic                   stallD,
  input  logic                   branchTakenE,
  input  logic [ADDRWIDTH-1:0]   branchTargetE,
  output logic [WIDTH-1:0]       instrD,
  output logic [ADDRWIDTH-1:0]   pcD,
  output logic [OPCODEWIDTH-1:0] opcodeD,
  output logic                   validD
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]            fetchCount,
  output logic [31:0]            discardCount
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t               state, state_n;
  logic [ADDRWIDTH-1:0] pcF, pc_n;
  logic [WIDTH-1:0]     buf_instr;
  logic [ADDRWIDTH-1:0] buf_pc;
  logic                 load, to_buf, drop;
  logic [WIDTH-1:0]     load_instr;
  logic [ADDRWIDTH-1:0] load_pc;

  // Request is masked while reset is held so the strobe reads 0 in reset.
  assign imemReqF  = (state == S_FETCH) && !reset;
  assign imemAddrF = pcF;
  assign opcodeD   = validD ? instrD[WIDTH-1 -: OPCODEWIDTH] : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_n    = state;
    pc_n       = pcF;
    load       = 1'b0;
    to_buf     = 1'b0;
    drop       = 1'b0;
    load_instr = imemDataF;
    load_pc    = pcF;
    if (branchTakenE) begin
      pc_n = branchTargetE;
      unique case (state)
        S_FETCH: state_n = S_DRAIN;
        S_HOLD: begin
          state_n = S_FETCH;
          drop    = 1'b1;
        end
        // The in-flight word may land in the redirect cycle itself; retire it here.
        default: begin
          state_n = imemValidF ? S_FETCH : S_DRAIN;
          drop    = imemValidF;
        end
      endcase
    end else begin
      unique case (state)
        S_FETCH: state_n = S_WAIT;
        S_WAIT: begin
          if (imemValidF && !stallD) begin
            load    = 1'b1;
            pc_n    = pcF + 1'b1;
            state_n = S_FETCH;
          end else if (imemValidF) begin
            to_buf  = 1'b1;
            state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stallD) begin
            load       = 1'b1;
            load_instr = buf_instr;
            load_pc    = buf_pc;
            pc_n       = pcF + 1'b1;
            state_n    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imemValidF) begin
            drop    = 1'b1;
            state_n = S_FETCH;
          end
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pcF   <= ADDRWIDTH'(RESETPC);
    end else begin
      state <= state_n;
      pcF   <= pc_n;
    end
  end

  // NOTE: the skid buffer is a single register, so it is reset rather than left as uninitialised storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (to_buf) begin
      buf_instr <= imemDataF;
      buf_pc    <= pcF;
    end else if (branchTakenE && state == S_HOLD) begin
      buf_instr <= '0;
      buf_pc    <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrD <= '0;
      pcD    <= '0;
      validD <= 1'b0;
    end else if (branchTakenE) begin
      validD <= 1'b0;
    end else if (load) begin
      instrD <= load_instr;
      pcD    <= load_pc;
      validD <= 1'b1;
    end else if (!stallD) begin
      validD <= 1'b0;
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCount   <= '0;
      discardCount <= '0;
    end else begin
      if (load && fetchCount != '1)   fetchCount   <= fetchCount + 1'b1;
      if (drop && discardCount != '1) discardCount <= discardCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit: a latency-programmable memory model answers 0x1000_0000 + addr.
// Inputs change 1 time unit after each falling edge; outputs are checked there.
`timescale 1ns/100ps
module tb_fetch_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReqF;
  logic [15:0] imemAddrF;
  logic [31:0] imemDataF;
  logic        imemValidF;
  logic        stallD;
  logic        branchTakenE;
  logic [15:0] branchTargetE;
  logic [31:0] instrD;
  logic [15:0] pcD;
  logic [3:0]  opcodeD;
  logic        validD;
`ifdef PERF_COUNTERS_EN
  logic [31:0] fetchCount, discardCount;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int mem_lat    = 1;

  fetch_issue_unit dut (
    .clk(clk), .reset(reset),
    .imemReqF(imemReqF), .imemAddrF(imemAddrF),
    .imemDataF(imemDataF), .imemValidF(imemValidF),
    .stallD(stallD), .branchTakenE(branchTakenE), .branchTargetE(branchTargetE),
    .instrD(instrD), .pcD(pcD), .opcodeD(opcodeD), .validD(validD)
`ifdef PERF_COUNTERS_EN
    , .fetchCount(fetchCount), .discardCount(discardCount)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: captures a request mid-cycle, returns it mem_lat cycles later for one cycle.
  initial begin
    logic        pending;
    int          rem;
    logic [15:0] paddr;
    pending    = 1'b0;
    rem        = 0;
    paddr      = '0;
    imemValidF = 1'b0;
    imemDataF  = '0;
    forever begin
      @(negedge clk); #2;
      if (reset) pending = 1'b0;
      else if (imemReqF && !pending) begin
        pending = 1'b1;
        rem     = mem_lat;
        paddr   = imemAddrF;
      end
      @(posedge clk); #1;
      imemValidF = 1'b0;
      if (reset) pending = 1'b0;
      else if (pending) begin
        rem = rem - 1;
        if (rem == 0) begin
          imemValidF = 1'b1;
          imemDataF  = 32'h1000_0000 + 32'(paddr);
          pending    = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stallD = 1'b0; branchTakenE = 1'b0; branchTargetE = '0;
    cyc();
    cyc();
    vectors++;
    if ({validD, instrD, pcD, opcodeD, imemReqF} !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%0b i=%h pc=%h op=%h req=%0b, expected all zero",
               validD, instrD, pcD, opcodeD, imemReqF);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({imemReqF, imemAddrF} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_first_req: got req=%0b addr=%h, expected req=1 addr=0000", imemReqF, imemAddrF);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if ({imemReqF, validD} !== 2'b00) begin
        miscompares++;
        $display("FAIL basic_wait[%0d]: got req=%0b v=%0b, expected 0 0", k, imemReqF, validD);
      end
      cyc();
      vectors++;
      if ({validD, pcD, instrD, opcodeD, imemReqF, imemAddrF} !==
          {1'b1, 16'(k), 32'h1000_0000 + 32'(k), 4'b0001, 1'b1, 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL basic_issue[%0d]: got v=%0b pc=%h i=%h op=%h req=%0b addr=%h, expected v=1 pc=%h i=%h op=1 req=1 addr=%h",
                 k, validD, pcD, instrD, opcodeD, imemReqF, imemAddrF, 16'(k), 32'h1000_0000 + 32'(k), 16'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    stallD = 1'b1;
    cyc();
    vectors++;
    if ({validD, pcD} !== {1'b1, 16'h0002}) begin
      miscompares++;
      $display("FAIL stall_fetch_hold: got v=%0b pc=%h, expected v=1 pc=0002", validD, pcD);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if ({imemReqF, validD, pcD, instrD} !== {1'b0, 1'b1, 16'h0002, 32'h1000_0002}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got req=%0b v=%0b pc=%h i=%h, expected req=0 v=1 pc=0002 i=10000002",
                 k, imemReqF, validD, pcD, instrD);
      end
    end
    stallD = 1'b0;
    cyc();
    vectors++;
    if ({validD, pcD, instrD, imemReqF, imemAddrF} !== {1'b1, 16'h0003, 32'h1000_0003, 1'b1, 16'h0004}) begin
      miscompares++;
      $display("FAIL stall_release: got v=%0b pc=%h i=%h req=%0b addr=%h, expected v=1 pc=0003 i=10000003 req=1 addr=0004",
               validD, pcD, instrD, imemReqF, imemAddrF);
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    cyc();
    branchTakenE = 1'b1; branchTargetE = 16'h0040;
    cyc();
    branchTakenE = 1'b0;
    vectors++;
    if ({imemReqF, validD} !== 2'b00) begin
      miscompares++;
      $display("FAIL redir_wait_drain: got req=%0b v=%0b, expected 0 0", imemReqF, validD);
    end
    cyc();
    vectors++;
    if ({imemReqF, validD} !== 2'b00) begin
      miscompares++;
      $display("FAIL redir_wait_drain2: got req=%0b v=%0b, expected 0 0", imemReqF, validD);
    end
    cyc();
    mem_lat = 1;
    vectors++;
    if ({imemReqF, imemAddrF, validD} !== {1'b1, 16'h0040, 1'b0}) begin
      miscompares++;
      $display("FAIL redir_wait_target: got req=%0b addr=%h v=%0b, expected req=1 addr=0040 v=0", imemReqF, imemAddrF, validD);
    end
    cyc();
    cyc();
    vectors++;
    if ({validD, pcD, instrD} !== {1'b1, 16'h0040, 32'h1000_0040}) begin
      miscompares++;
      $display("FAIL redir_wait_issue: got v=%0b pc=%h i=%h, expected v=1 pc=0040 i=10000040", validD, pcD, instrD);
    end
  endtask

  task automatic test_redirect_hold();
    stallD = 1'b1;
    cyc();
    cyc();
    vectors++;
    if ({imemReqF, validD, pcD} !== {1'b0, 1'b1, 16'h0040}) begin
      miscompares++;
      $display("FAIL hold_entry: got req=%0b v=%0b pc=%h, expected req=0 v=1 pc=0040", imemReqF, validD, pcD);
    end
    branchTakenE = 1'b1; branchTargetE = 16'h0080;
    cyc();
    vectors++;
    if ({validD, opcodeD, imemReqF, imemAddrF} !== {1'b0, 4'h0, 1'b1, 16'h0080}) begin
      miscompares++;
      $display("FAIL hold_redirect: got v=%0b op=%h req=%0b addr=%h, expected v=0 op=0 req=1 addr=0080",
               validD, opcodeD, imemReqF, imemAddrF);
    end
    branchTakenE = 1'b0; stallD = 1'b0;
    cyc();
    cyc();
    vectors++;
    if ({validD, pcD, instrD} !== {1'b1, 16'h0080, 32'h1000_0080}) begin
      miscompares++;
      $display("FAIL hold_redirect_issue: got v=%0b pc=%h i=%h, expected v=1 pc=0080 i=10000080", validD, pcD, instrD);
    end
  endtask

  task automatic test_wrap();
    branchTakenE = 1'b1; branchTargetE = 16'hFFFF;
    cyc();
    branchTakenE = 1'b0;
    cyc();
    vectors++;
    if ({imemReqF, imemAddrF} !== {1'b1, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL wrap_req: got req=%0b addr=%h, expected req=1 addr=ffff", imemReqF, imemAddrF);
    end
    cyc();
    cyc();
    vectors++;
    if ({validD, pcD, instrD, imemReqF, imemAddrF} !== {1'b1, 16'hFFFF, 32'h1000_FFFF, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL wrap_next: got v=%0b pc=%h i=%h req=%0b addr=%h, expected v=1 pc=ffff i=1000ffff req=1 addr=0000",
               validD, pcD, instrD, imemReqF, imemAddrF);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    cyc();
    reset = 1'b1;
    #1;
    vectors++;
    if ({validD, instrD, pcD, opcodeD, imemReqF} !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%0b i=%h pc=%h op=%h req=%0b, expected all zero",
               validD, instrD, pcD, opcodeD, imemReqF);
    end
`ifdef PERF_COUNTERS_EN
    vectors++;
    if ({fetchCount, discardCount} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got fetch=%0d discard=%0d, expected 0 0", fetchCount, discardCount);
    end
`endif
    cyc();
    mem_lat = 1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({imemReqF, imemAddrF} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_mid_req: got req=%0b addr=%h, expected req=1 addr=0000", imemReqF, imemAddrF);
    end
    cyc();
    cyc();
    vectors++;
    if ({validD, pcD, instrD} !== {1'b1, 16'h0000, 32'h1000_0000}) begin
      miscompares++;
      $display("FAIL reset_mid_issue: got v=%0b pc=%h i=%h, expected v=1 pc=0000 i=10000000", validD, pcD, instrD);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
